// File: rtl/johnson_pkg.sv
// Shared state encoding, error-counter limit and Johnson word legality/decode helpers.
package johnson_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] ERR_MAX = 8'd255;

  // A Johnson word has at most one boundary between adjacent bits.
  function automatic logic jc_legal(input logic [31:0] c, input int w);
    int t;
    t = 0;
    for (int i = 0; i < 31; i++) begin
      if (i < w - 1 && c[i] != c[i+1]) t++;
    end
    return (t <= 1);
  endfunction

  function automatic int jc_index(input logic [31:0] c, input int w);
    int ones;
    ones = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < w && c[i]) ones++;
    end
    return c[0] ? (2 * w - ones) : ones;
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational Johnson word check: legality flag and binary index 0..2*WIDTH-1.
// Zero latency, no flow control.
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int IW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [IW-1:0]    index
);

  assign legal = jc_legal(32'(code), WIDTH);
  assign index = IW'(jc_index(32'(code), WIDTH));

endmodule

// File: rtl/johnson_decoder.sv
// Johnson code decoder with hunt/check/lock sequence tracking and saturating loss counter.
// All outputs registered, 1-cycle latency; accepts a sample every cycle, no backpressure.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int WIDTH      = 6,
  parameter int LOCK_COUNT = 3,
  parameter int IW         = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [WIDTH-1:0] code,
  output logic [IW-1:0]    index,
  output logic             legal,
  output logic             locked,
  output logic             seq_err,
  output logic [7:0]       err_count
);

  localparam int             MW       = $clog2(LOCK_COUNT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(2 * WIDTH - 1);
  localparam logic [MW-1:0] LOCK_PRE = MW'(LOCK_COUNT - 1);

  state_t          state_q, state_d;
  logic [MW-1:0]   match_q, match_d;
  logic [IW-1:0]   index_d;
  logic            legal_d, locked_d, seq_err_d;
  logic [7:0]      err_d;

  logic            dec_legal;
  logic [IW-1:0]   dec_index;
  logic [IW-1:0]   exp_index;
  logic            is_exp, is_hold;

  johnson_code_check #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_check (
    .code  (code),
    .legal (dec_legal),
    .index (dec_index)
  );

  assign exp_index = (index == LAST_IDX) ? '0 : index + 1'b1;
  assign is_exp    = dec_legal && (dec_index == exp_index);
  assign is_hold   = dec_legal && (dec_index == index);

  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    index_d   = index;
    legal_d   = legal;
    locked_d  = locked;
    seq_err_d = 1'b0;
    err_d     = err_count;
    if (valid) begin
      legal_d = dec_legal;
      if (dec_legal) index_d = dec_index;
      case (state_q)
        HUNT: begin
          if (dec_legal) begin
            state_d = CHECK;
            match_d = MW'(1);
          end
        end
        CHECK: begin
          if (!dec_legal) begin
            state_d = HUNT;
            match_d = '0;
          end else if (is_exp) begin
            match_d = match_q + 1'b1;
            if (match_q == LOCK_PRE) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else if (!is_hold) begin
            match_d = MW'(1);
          end
        end
        LOCKED: begin
          // A legal sample that breaks lock still updates index but does not seed CHECK.
          if (!(is_exp || is_hold)) begin
            state_d   = HUNT;
            match_d   = '0;
            locked_d  = 1'b0;
            seq_err_d = 1'b1;
            err_d     = (err_count == ERR_MAX) ? err_count : err_count + 8'd1;
          end
        end
        default: begin
          state_d  = HUNT;
          match_d  = '0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= HUNT;
      match_q   <= '0;
      index     <= '0;
      legal     <= 1'b0;
      locked    <= 1'b0;
      seq_err   <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      index     <= index_d;
      legal     <= legal_d;
      locked    <= locked_d;
      seq_err   <= seq_err_d;
      err_count <= err_d;
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// Bench for johnson_decoder: directed scenarios plus random traffic against a table-driven model.
module tb_johnson_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic [5:0] code = 6'd0;
  logic [3:0] index;
  logic       legal, locked, seq_err;
  logic [7:0] err_count;

  int errors = 0;
  int checks = 0;

  johnson_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .code      (code),
    .index     (index),
    .legal     (legal),
    .locked    (locked),
    .seq_err   (seq_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Reference: the 12 legal words listed in counting order; position in the list is the index.
  logic [5:0] jw [12];
  int m_state, m_match, m_index, m_err;
  logic m_legal, m_locked, m_seqerr;

  function automatic int lookup(input logic [5:0] c);
    for (int k = 0; k < 12; k++) if (jw[k] == c) return k;
    return -1;
  endfunction

  task automatic build_table();
    for (int k = 0; k < 12; k++) begin
      if (k <= 6) jw[k] = 6'(((1 << k) - 1) << (6 - k));
      else        jw[k] = 6'((1 << (12 - k)) - 1);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_match = 0; m_index = 0; m_err = 0;
    m_legal = 0; m_locked = 0; m_seqerr = 0;
  endtask

  task automatic model_update(input logic v, input logic [5:0] c);
    int k, expk;
    m_seqerr = 0;
    if (!v) return;
    k = lookup(c);
    expk = (m_index + 1) % 12;
    m_legal = (k >= 0);
    case (m_state)
      0: if (k >= 0) begin m_index = k; m_state = 1; m_match = 1; end
      1: begin
        if (k < 0) begin m_state = 0; m_match = 0; end
        else if (k == expk) begin
          m_index = k; m_match++;
          if (m_match == 3) begin m_state = 2; m_locked = 1; end
        end else if (k != m_index) begin m_index = k; m_match = 1; end
      end
      default: begin
        if (k >= 0 && (k == expk || k == m_index)) m_index = k;
        else begin
          if (k >= 0) m_index = k;
          m_seqerr = 1; m_locked = 0; m_state = 0; m_match = 0;
          if (m_err < 255) m_err++;
        end
      end
    endcase
  endtask

  task automatic step(input logic v, input logic [5:0] c);
    @(negedge clk);
    valid = v;
    code  = c;
    @(posedge clk);
    model_update(v, c);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    valid = 1'b0;
    #1 model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; valid = 1'b1; code = 6'b101010;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({index, legal, locked, seq_err, err_count} !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got idx=%0d legal=%0b locked=%0b seq_err=%0b err=%0d, want all 0",
               index, legal, locked, seq_err, err_count);
    end
    @(negedge clk); reset = 1'b1; valid = 1'b0;
    step(1, 6'b000000); step(1, 6'b100000);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL lock_early: locked=%0b want 0 after two samples", locked);
    end
    step(1, 6'b110000);
    checks++;
    if (locked !== 1'b1 || index !== 4'd2 || legal !== 1'b1) begin
      errors++;
      $display("FAIL lock_acquire: locked=%0b idx=%0d legal=%0b want 1/2/1", locked, index, legal);
    end
  endtask

  task automatic test_wrap();
    for (int k = 3; k <= 12; k++) begin
      step(1, jw[k % 12]);
      checks++;
      if (index !== 4'(k % 12) || locked !== 1'b1 || seq_err !== 1'b0) begin
        errors++;
        $display("FAIL wrap_k%0d: idx=%0d locked=%0b seq_err=%0b want %0d/1/0",
                 k, index, locked, seq_err, k % 12);
      end
    end
  endtask

  task automatic test_illegal_loss();
    do_reset();
    for (int k = 0; k <= 4; k++) step(1, jw[k]);
    step(1, 6'b101100);
    checks++;
    if (legal !== 1'b0 || seq_err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || index !== 4'd4) begin
      errors++;
      $display("FAIL illegal_loss: legal=%0b seq_err=%0b err=%0d locked=%0b idx=%0d want 0/1/1/0/4",
               legal, seq_err, err_count, locked, index);
    end
    step(0, 6'b000000);
    checks++;
    if (seq_err !== 1'b0 || err_count !== 8'd1) begin
      errors++; $display("FAIL seq_err_pulse: seq_err=%0b err=%0d want 0/1", seq_err, err_count);
    end
  endtask

  task automatic test_hold_idle();
    logic [15:0] snap;
    do_reset();
    for (int k = 0; k <= 3; k++) step(1, jw[k]);
    for (int r = 0; r < 5; r++) begin
      step(1, 6'b111000);
      checks++;
      if (index !== 4'd3 || locked !== 1'b1 || seq_err !== 1'b0) begin
        errors++; $display("FAIL hold_r%0d: idx=%0d locked=%0b seq_err=%0b want 3/1/0", r, index, locked, seq_err);
      end
    end
    step(1, 6'b111100);
    checks++;
    if (index !== 4'd4 || locked !== 1'b1 || err_count !== 8'd0) begin
      errors++; $display("FAIL hold_advance: idx=%0d locked=%0b err=%0d want 4/1/0", index, locked, err_count);
    end
    snap = {index, legal, locked, seq_err, err_count};
    for (int r = 0; r < 3; r++) begin
      step(0, 6'($urandom));
      checks++;
      if ({index, legal, locked, seq_err, err_count} !== snap) begin
        errors++; $display("FAIL idle_r%0d: outputs=%h want %h", r, {index, legal, locked, seq_err, err_count}, snap);
      end
    end
  endtask

  task automatic test_reseed();
    do_reset();
    step(1, 6'b110000);
    step(1, 6'b011111);
    checks++;
    if (index !== 4'd7 || locked !== 1'b0 || legal !== 1'b1) begin
      errors++; $display("FAIL reseed: idx=%0d locked=%0b legal=%0b want 7/0/1", index, locked, legal);
    end
    step(1, 6'b001111);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL reseed_count: locked=%0b want 0 after second sample", locked);
    end
    step(1, 6'b000111);
    checks++;
    if (index !== 4'd9 || locked !== 1'b1) begin
      errors++; $display("FAIL reseed_lock: idx=%0d locked=%0b want 9/1", index, locked);
    end
  endtask

  task automatic test_random();
    logic [5:0] c;
    int sel;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 55)      c = jw[(m_index + 1) % 12];
      else if (sel < 70) c = jw[m_index];
      else if (sel < 85) c = jw[$urandom_range(0, 11)];
      else               c = 6'($urandom);
      step(($urandom_range(0, 9) != 0), c);
      checks++;
      if (index !== 4'(m_index) || legal !== m_legal || locked !== m_locked ||
          seq_err !== m_seqerr || err_count !== 8'(m_err)) begin
        errors++;
        $display("FAIL random_n%0d: got idx=%0d legal=%0b lk=%0b se=%0b err=%0d want %0d/%0b/%0b/%0b/%0d",
                 n, index, legal, locked, seq_err, err_count, m_index, m_legal, m_locked, m_seqerr, m_err);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int n = 0; n < 256; n++) begin
      step(1, jw[0]); step(1, jw[1]); step(1, jw[2]);
      step(1, 6'b101010);
      if (n >= 253) begin
        checks++;
        if (seq_err !== 1'b1 || err_count !== 8'(m_err)) begin
          errors++; $display("FAIL sat_n%0d: seq_err=%0b err=%0d want 1/%0d", n, seq_err, err_count, m_err);
        end
      end
    end
    checks++;
    if (err_count !== 8'd255) begin
      errors++; $display("FAIL sat_final: err=%0d want 255", err_count);
    end
  endtask

  task automatic test_async_reset();
    step(1, jw[0]); step(1, jw[1]); step(1, jw[2]);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL pre_reset_lock: locked=%0b want 1", locked);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({index, legal, locked, seq_err, err_count} !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: idx=%0d legal=%0b locked=%0b seq_err=%0b err=%0d want all 0",
               index, legal, locked, seq_err, err_count);
    end
    model_reset();
    @(negedge clk); reset = 1'b1;
  endtask

  initial begin
    build_table();
    test_reset();
    test_wrap();
    test_illegal_loss();
    test_hold_idle();
    test_reseed();
    test_random();
    test_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
